// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper:
// joystick word bit positions and PS/2 scan codes.
package arcade_input_pkg;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_Z      = 8'h1A;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_F2     = 8'h06;
  localparam logic [7:0] SC_F3     = 8'h04;
  localparam logic [7:0] SC_F4     = 8'h0C;
  localparam logic [7:0] SC_F5     = 8'h03;

  localparam int NKEYS = 14;

  typedef enum logic [3:0] {
    K_UP,
    K_DOWN,
    K_LEFT,
    K_RIGHT,
    K_CTRL,
    K_ALT,
    K_SPACE,
    K_LSHIFT,
    K_Z,
    K_F1,
    K_F2,
    K_F3,
    K_F4,
    K_F5,
    K_NONE
  } key_e;

  function automatic int BTN_BIT(input int k);
    return 4 + k;
  endfunction

  function automatic int START1_BIT(input int nbtn);
    return 4 + nbtn;
  endfunction

  function automatic int START2_BIT(input int nbtn);
    return 5 + nbtn;
  endfunction

  function automatic int COIN_BIT(input int nbtn);
    return 6 + nbtn;
  endfunction

  function automatic int PAUSE_BIT(input int nbtn);
    return 7 + nbtn;
  endfunction

  function automatic key_e key_of(input logic [7:0] code);
    key_e k;
    case (code)
      SC_UP:     k = K_UP;
      SC_DOWN:   k = K_DOWN;
      SC_LEFT:   k = K_LEFT;
      SC_RIGHT:  k = K_RIGHT;
      SC_CTRL:   k = K_CTRL;
      SC_ALT:    k = K_ALT;
      SC_SPACE:  k = K_SPACE;
      SC_LSHIFT: k = K_LSHIFT;
      SC_Z:      k = K_Z;
      SC_F1:     k = K_F1;
      SC_F2:     k = K_F2;
      SC_F3:     k = K_F3;
      SC_F4:     k = K_F4;
      SC_F5:     k = K_F5;
      default:   k = K_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/arcade_pulse_stretch.sv
// Rising-edge triggered pulse of TICKS cen ticks;
// edges seen while the pulse is running are ignored.
module arcade_pulse_stretch #(
  parameter int TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cen,
  input  logic src,
  output logic pulse
);

  localparam int CW = $clog2(TICKS + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          src_q;

  always_comb begin
    cnt_next = cnt;
    if (cnt == '0) begin
      if (src && !src_q) cnt_next = CW'(TICKS);
    end else if (cen) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // src_q loads the live source on reset so a held
  // source does not retrigger once reset drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      src_q <= src;
      pulse <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      src_q <= src;
      pulse <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 keys and joysticks merged into
// per-player direction, button, start, coin, pause and test.
module arcade_input_mapper #(
  parameter int NPLAYERS   = 2,
  parameter int NBTN       = 2,
  parameter int COIN_TICKS = 8,
  parameter int AF_HALF    = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     cen,
  input  logic [10:0]              ps2_key,
  input  logic [16*NPLAYERS-1:0]   joy,
  input  logic                     separate,
  input  logic [NBTN-1:0]          af_en,
  output logic [4*NPLAYERS-1:0]    dir,
  output logic [NBTN*NPLAYERS-1:0] btn,
  output logic [NPLAYERS-1:0]      start,
  output logic [NPLAYERS-1:0]      coin,
  output logic                     pause,
  output logic                     test
);

  import arcade_input_pkg::*;

  localparam int S1  = START1_BIT(NBTN);
  localparam int S2  = START2_BIT(NBTN);
  localparam int CB  = COIN_BIT(NBTN);
  localparam int PB  = PAUSE_BIT(NBTN);
  localparam int AFW = $clog2(AF_HALF + 1);
  localparam int NB  = NBTN * NPLAYERS;
  localparam logic INV = (ACTIVE_LOW != 0);

  logic              t_q;
  logic              evt;
  key_e              kid;
  logic [NKEYS-1:0]  keys;
  logic [15:0]       kb;
  logic [15:0]       joy_or;
  logic [16*NPLAYERS-1:0] src;

  logic [4*NPLAYERS-1:0] dir_raw;
  logic [NB-1:0]         held;
  logic [NB-1:0]         btn_raw;
  logic [NPLAYERS-1:0]   start_raw;
  logic [NPLAYERS-1:0]   coin_src;
  logic                  any_af;
  logic                  psrc;

  logic [4*NPLAYERS-1:0] dir_q;
  logic [NB-1:0]         btn_q;
  logic [NPLAYERS-1:0]   start_q;
  logic [NPLAYERS-1:0]   coin_q;
  logic                  pause_q;
  logic                  pause_prev;
  logic                  test_q;
  logic                  ph;
  logic [AFW-1:0]        af_cnt;

  assign evt = (ps2_key[10] != t_q);
  assign kid = key_of(ps2_key[7:0]);

  // One latch per key, so two keys on one function never cancel.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      t_q  <= ps2_key[10];
      keys <= '0;
    end else begin
      t_q <= ps2_key[10];
      if (evt && kid != K_NONE) keys[kid] <= ps2_key[9];
    end
  end

  always_comb begin
    kb = '0;
    kb[3:0] = {keys[K_UP], keys[K_DOWN],
               keys[K_LEFT], keys[K_RIGHT]};
    kb[BTN_BIT(0)] = keys[K_CTRL] | keys[K_ALT];
    if (NBTN > 1) kb[BTN_BIT(1)] = keys[K_SPACE];
    if (NBTN > 2) kb[BTN_BIT(2)] = keys[K_LSHIFT];
    if (NBTN > 3) kb[BTN_BIT(3)] = keys[K_Z];
    kb[S1] = keys[K_F1];
    kb[S2] = keys[K_F2];
    kb[CB] = keys[K_F3];
    kb[PB] = keys[K_F4];
  end

  always_comb begin
    joy_or = '0;
    for (int i = 0; i < NPLAYERS; i++) begin
      joy_or = joy_or | joy[16*i +: 16];
    end
    for (int i = 0; i < NPLAYERS; i++) begin
      src[16*i +: 16] = (separate ? joy[16*i +: 16] : joy_or)
                      | ((i == 0) ? kb : 16'h0);
    end
  end

  always_comb begin
    dir_raw   = '0;
    held      = '0;
    start_raw = '0;
    coin_src  = '0;
    for (int i = 0; i < NPLAYERS; i++) begin
      dir_raw[4*i +: 4] = src[16*i +: 4];
      coin_src[i]       = src[16*i + CB];
      for (int k = 0; k < NBTN; k++) begin
        held[NBTN*i + k] = src[16*i + BTN_BIT(k)];
      end
      // Merged mode only drives start[0] from Start1P.
      start_raw[i] = (i == 0 || separate) && src[16*i + S1];
      if (i == 1) start_raw[i] = start_raw[i] | joy_or[S2] | kb[S2];
    end
  end

  assign any_af = |(held & {NPLAYERS{af_en}});
  assign psrc   = kb[PB] | joy_or[PB];

  always_comb begin
    btn_raw = '0;
    for (int i = 0; i < NPLAYERS; i++) begin
      for (int k = 0; k < NBTN; k++) begin
        btn_raw[NBTN*i + k] = held[NBTN*i + k]
                            & (af_en[k] ? ph : 1'b1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dir_q      <= '0;
      btn_q      <= '0;
      start_q    <= '0;
      test_q     <= 1'b0;
      pause_q    <= 1'b0;
      pause_prev <= psrc;
      ph         <= 1'b1;
      af_cnt     <= '0;
    end else begin
      dir_q      <= dir_raw;
      btn_q      <= btn_raw;
      start_q    <= start_raw;
      test_q     <= keys[K_F5];
      pause_prev <= psrc;
      if (psrc && !pause_prev) pause_q <= ~pause_q;
      // Phase parks high so a fresh press fires at once.
      if (!any_af) begin
        ph     <= 1'b1;
        af_cnt <= '0;
      end else if (cen) begin
        if (af_cnt == AFW'(AF_HALF - 1)) begin
          ph     <= ~ph;
          af_cnt <= '0;
        end else begin
          af_cnt <= af_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NPLAYERS; i++) begin : g_coin
    arcade_pulse_stretch #(
      .TICKS(COIN_TICKS)
    ) u_coin (
      .clk  (clk_sys),
      .reset(reset),
      .cen  (cen),
      .src  (coin_src[i]),
      .pulse(coin_q[i])
    );
  end

  assign dir   = dir_q   ^ {(4*NPLAYERS){INV}};
  assign btn   = btn_q   ^ {NB{INV}};
  assign start = start_q ^ {NPLAYERS{INV}};
  assign coin  = coin_q  ^ {NPLAYERS{INV}};
  assign pause = pause_q ^ INV;
  assign test  = test_q  ^ INV;

  logic unused;
  assign unused = ^{ps2_key[8], src};

endmodule
